ram_sdp_sr_clr: RTL and testbench

//  Parametrised simple-dual-port RAM (1 write port, 1 read port), synchronous read with 1- or 2-cycle

---
 rtl/ldpc_mem_pkg.sv | 12 +
 rtl/ram_clr_seq.sv | 55 +++++
 rtl/ram_sdp_sr_clr.sv | 122 ++++++++++++
 tb/tb_ram_sdp_sr_clr.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_mem_pkg.sv
// rtl/ldpc_mem_pkg.sv - shared types and constants for the LDPC message/LLR store
package ldpc_mem_pkg;

    localparam bit RW_READ_FIRST  = 1'b0;
    localparam bit RW_WRITE_FIRST = 1'b1;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

endpackage

// File: rtl/ram_clr_seq.sv
// rtl/ram_clr_seq.sv - clear sweep sequencer: walks every entry once, writing zero
module ram_clr_seq
    import ldpc_mem_pkg::*;
#(
    parameter int A_WIDTH      = 8,
    parameter int RAM_DEPTH    = 256,
    parameter int CLR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_req,
    output logic               busy,
    output logic               clr_we,
    output logic [A_WIDTH-1:0] clr_addr
);

    // Terminal compare against the last index keeps a full 2**A_WIDTH sweep from wrapping.
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(RAM_DEPTH - 1);

    clr_state_t         state;
    logic [A_WIDTH-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (CLR_ON_RESET != 0) ? CLR_SWEEP : CLR_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state <= CLR_SWEEP;
                        ptr   <= '0;
                    end
                end
                CLR_SWEEP: begin
                    if (ptr == LAST_ADDR) begin
                        state <= CLR_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= CLR_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == CLR_SWEEP);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/ram_sdp_sr_clr.sv
// rtl/ram_sdp_sr_clr.sv - simple-dual-port sync-read RAM with read-valid and clear sweep
module ram_sdp_sr_clr
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int A_WIDTH      = 8,
    parameter int RAM_DEPTH    = 256,
    parameter int RD_LAT       = 1,
    parameter int RW_MODE      = 0,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  we,
    input  logic [A_WIDTH-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [A_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    // When the array spans the whole address space every address is legal.
    localparam bit                 FULL_SPAN = (RAM_DEPTH >= (1 << A_WIDTH));
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(RAM_DEPTH - 1);
    localparam bit                 WR_FIRST  = (RW_MODE == int'(RW_WRITE_FIRST));

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  clr_we;
    logic [A_WIDTH-1:0]    clr_addr;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  mem_we;
    logic [A_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    ram_clr_seq #(
        .A_WIDTH      (A_WIDTH),
        .RAM_DEPTH    (RAM_DEPTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_in_range = FULL_SPAN || (wr_addr <= LAST_ADDR);
    assign rd_in_range = FULL_SPAN || (rd_addr <= LAST_ADDR);
    assign wr_ok       = we && !busy && wr_in_range;
    assign rd_ok       = re && !busy;

    // The sweep owns the write port while busy.
    assign mem_we    = clr_we || wr_ok;
    assign mem_addr  = clr_we ? clr_addr : wr_addr;
    assign mem_wdata = clr_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = '0;
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (WR_FIRST && wr_ok && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end else begin
            rd_word = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_sr_clr.sv
// tb/tb_ram_sdp_sr_clr.sv - self-checking bench: three configurations against a reference model
module tb_ram_sdp_sr_clr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       we;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       re;
    logic [3:0] rd_addr;

    logic [7:0] rdat0, rdat1, rdat2;
    logic       rval0, rval1, rval2;
    logic       bsy0, bsy1, bsy2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // dut0: lat 1 read-first, dut1: lat 2 write-first, dut2: lat 1 read-first depth 12
    ram_sdp_sr_clr #(.DATA_WIDTH(8), .A_WIDTH(4), .RAM_DEPTH(16), .RD_LAT(1), .RW_MODE(0), .CLR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(bsy0), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rdat0), .rd_valid(rval0));
    ram_sdp_sr_clr #(.DATA_WIDTH(8), .A_WIDTH(4), .RAM_DEPTH(16), .RD_LAT(2), .RW_MODE(1), .CLR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(bsy1), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rdat1), .rd_valid(rval1));
    ram_sdp_sr_clr #(.DATA_WIDTH(8), .A_WIDTH(4), .RAM_DEPTH(12), .RD_LAT(1), .RW_MODE(0), .CLR_ON_RESET(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(bsy2), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rdat2), .rd_valid(rval2));

    // Reference model: array contents, remaining sweep cycles, and a delay line of read results.
    int         dep [3] = '{16, 16, 12};
    int         lat [3] = '{1, 2, 1};
    int         rwm [3] = '{0, 1, 0};
    logic [7:0] m_mem [3][16];
    int         sweep_left [3];
    logic       pv [3][2];
    logic [7:0] pd [3][2];
    logic       m_val [3];
    logic [7:0] m_dat [3];
    logic       m_busy [3];

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
    } vec_t;

    vec_t tbl [7];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            sweep_left[k] = dep[k];
            m_busy[k]     = 1'b1;
            m_val[k]      = 1'b0;
            m_dat[k]      = 8'h00;
            for (int s = 0; s < 2; s++) begin
                pv[k][s] = 1'b0;
                pd[k][s] = 8'h00;
            end
        end
    endtask

    task automatic model_step();
        logic       rv;
        logic [7:0] rd;
        if (rst_n !== 1'b1) return;
        for (int k = 0; k < 3; k++) begin
            rv = 1'b0;
            rd = 8'h00;
            if (sweep_left[k] > 0) begin
                sweep_left[k]--;
                if (sweep_left[k] == 0) begin
                    for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
                end
            end else begin
                if (clr_req) sweep_left[k] = dep[k];
                if (re) begin
                    rv = 1'b1;
                    if (int'(rd_addr) >= dep[k]) rd = 8'h00;
                    else if (rwm[k] == 1 && we && wr_addr == rd_addr) rd = wr_data;
                    else rd = m_mem[k][rd_addr];
                end
                if (we && int'(wr_addr) < dep[k]) m_mem[k][wr_addr] = wr_data;
            end
            pv[k][1] = pv[k][0];
            pd[k][1] = pd[k][0];
            pv[k][0] = rv;
            pd[k][0] = rd;
            m_val[k] = pv[k][lat[k] - 1];
            if (m_val[k]) m_dat[k] = pd[k][lat[k] - 1];
            m_busy[k] = (sweep_left[k] > 0);
        end
    endtask

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] act_d(input int k);
        case (k)
            0:       return rdat0;
            1:       return rdat1;
            default: return rdat2;
        endcase
    endfunction

    function automatic logic act_v(input int k);
        case (k)
            0:       return rval0;
            1:       return rval1;
            default: return rval2;
        endcase
    endfunction

    function automatic logic act_b(input int k);
        case (k)
            0:       return bsy0;
            1:       return bsy1;
            default: return bsy2;
        endcase
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, {7'd0, act_b(k)}, {7'd0, m_busy[k]});
            chk("rd_valid", k, {7'd0, act_v(k)}, {7'd0, m_val[k]});
            chk("rd_data", k, act_d(k), m_dat[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        re      = 1'b0;
        clr_req = 1'b0;
        wr_addr = 4'd0;
        rd_addr = 4'd0;
        wr_data = 8'h00;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bsy0 === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    int cnt;

    initial begin
        tbl[0] = '{1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b1, 8'hA5, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h3C, 1'b1, 8'h3C};
        tbl[3] = '{1'b1, 4'd7, 8'h11, 1'b1, 4'd6, 1'b1, 8'hA6, 1'b1, 8'h3C};
        tbl[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 8'hA6};
        tbl[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 8'h11, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 8'h11};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;

        // Reset state and power-on sweep
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        chk("por_sweep_len", 0, 8'(cnt), 8'd16);

        for (int i = 0; i < 16; i++) begin
            re = 1'b1;
            rd_addr = 4'(i);
            step();
            chk("zero_after_sweep", 0, rdat0, 8'h00);
            chk("zero_valid", 0, {7'd0, rval0}, 8'd1);
        end
        idle_inputs();
        step();
        step();

        // Fill and read back at both latencies
        for (int i = 0; i < 16; i++) begin
            we = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'hA0 + 8'(i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            re = 1'b1;
            rd_addr = 4'(i);
            step();
            chk("readback_lat1", 0, rdat0, 8'hA0 + 8'(i));
            if (i > 0) chk("readback_lat2", 1, rdat1, 8'hA0 + 8'(i - 1));
        end
        idle_inputs();
        step();
        chk("readback_lat2_last", 1, rdat1, 8'hAF);
        chk("lat1_valid_drop", 0, {7'd0, rval0}, 8'd0);
        step();

        // Same-address read/write collision and latency table
        for (int r = 0; r < 7; r++) begin
            we = tbl[r].we;
            wr_addr = tbl[r].wa;
            wr_data = tbl[r].wd;
            re = tbl[r].re;
            rd_addr = tbl[r].ra;
            step();
            chk("tbl_v0", r, {7'd0, rval0}, {7'd0, tbl[r].v0});
            if (tbl[r].v0) chk("tbl_d0", r, rdat0, tbl[r].d0);
            chk("tbl_v1", r, {7'd0, rval1}, {7'd0, tbl[r].v1});
            if (tbl[r].v1) chk("tbl_d1", r, rdat1, tbl[r].d1);
        end
        idle_inputs();

        // Out-of-range access on the depth-12 instance
        we = 1'b1; wr_addr = 4'd13; wr_data = 8'h5A;
        step();
        we = 1'b0; re = 1'b1; rd_addr = 4'd13;
        step();
        chk("oor_data", 2, rdat2, 8'h00);
        chk("oor_valid", 2, {7'd0, rval2}, 8'd1);
        chk("inrange_13", 0, rdat0, 8'h5A);
        rd_addr = 4'd11;
        step();
        chk("addr11_intact", 2, rdat2, 8'hAB);
        idle_inputs();
        step();

        // Clear request during reads, second request mid-sweep, traffic ignored while busy
        re = 1'b1; rd_addr = 4'd3;
        step();
        clr_req = 1'b1; rd_addr = 4'd4;
        step();
        chk("pre_busy_read", 0, rdat0, 8'hA4);
        clr_req = 1'b0;
        cnt = 0;
        while (bsy0 === 1'b1 && cnt < 100) begin
            cnt++;
            we = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            re = 1'($urandom); rd_addr = 4'($urandom);
            clr_req = (cnt == 8);
            step();
        end
        chk("sweep_len_retrigger", 0, 8'(cnt), 8'd16);
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            re = 1'b1;
            rd_addr = 4'(i);
            step();
            chk("zero_after_clr", 0, rdat0, 8'h00);
        end
        idle_inputs();
        step();

        // Reset with a read in flight on the two-stage instance
        re = 1'b1; rd_addr = 4'd2;
        step();
        re = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_drop_valid", 1, {7'd0, rval1}, 8'd0);
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        chk("sweep_len_after_rst", 0, 8'(cnt), 8'd16);

        // Reset at sweep pointer 7
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_sweep_valid", 0, {7'd0, rval0}, 8'd0);
        chk("rst_mid_sweep_busy", 0, {7'd0, bsy0}, 8'd1);
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        chk("restart_sweep_len", 0, 8'(cnt), 8'd16);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            we = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            re = 1'($urandom); rd_addr = 4'($urandom);
            clr_req = ($urandom_range(63, 0) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
